bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the BCD-to-excess-3 stage. Its registered BCD digits feed that stage's 4-bit input, one nibble per digit.
- Uses a start/busy/done handshake so that a controller or bench can launch conversions back to back.

---
 rtl/bin_to_bcd_seq_if.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 93 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done handshake bundle for the sequential binary-to-BCD converter.
//   start    : conversion request from the controller
//   bin      : W-bit binary operand, taken on the edge that accepts start
//   busy     : conversion in progress
//   done     : one-cycle result strobe
//   bcd      : packed BCD result, nibble 0 is the least significant digit
//   overflow : operand needed more than DIGITS decimal digits
//   ex3      : excess-3 copy of bcd, present only with BIN_TO_BCD_EX3_OUT_EN
interface bin_to_bcd_seq_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                start;
    logic [W-1:0]        bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                overflow;
`ifdef BIN_TO_BCD_EX3_OUT_EN
    logic [4*DIGITS-1:0] ex3;
    modport master (output start, bin, input busy, done, bcd, overflow, ex3);
    modport slave  (input start, bin, output busy, done, bcd, overflow, ex3);
`else
    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: double-dabble binary-to-BCD converter, one operand bit per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, takes priority over start
//   bus : bin_to_bcd_seq_if.slave (start/bin in; busy/done/bcd/overflow out)
// Optional macro BIN_TO_BCD_EX3_OUT_EN adds bus.ex3, the excess-3 form of bcd.
module bin_to_bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input logic              clk,
    input logic              rst,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_shift;
    logic [BW-1:0] r_scr;
    logic [BW-1:0] r_bcd;
    logic [CW-1:0] r_cnt;
    logic          r_sticky;
    logic          r_ovf;
    logic [BW-1:0] w_adj;
    logic [BW+W:0] w_cat;
    logic [BW-1:0] w_scr_nxt;
    logic          w_lost;
    logic          w_last;
`ifdef BIN_TO_BCD_EX3_OUT_EN
    logic [BW-1:0] r_ex3;
    logic [BW-1:0] w_ex3;
`endif

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign w_adj[4*d+:4] = (r_scr[4*d+:4] >= 4'd5) ? r_scr[4*d+:4] + 4'd3 : r_scr[4*d+:4];
`ifdef BIN_TO_BCD_EX3_OUT_EN
        assign w_ex3[4*d+:4] = w_scr_nxt[4*d+:4] + 4'd3;
`endif
    end

    // Appending a zero keeps the shift expression legal even for W=1.
    assign w_cat     = {w_adj, r_shift, 1'b0};
    assign w_scr_nxt = w_cat[BW+W-1:W];
    assign w_lost    = w_cat[BW+W];
    assign w_last    = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_scr    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_bcd    <= '0;
            r_ovf    <= 1'b0;
`ifdef BIN_TO_BCD_EX3_OUT_EN
            r_ex3    <= {DIGITS{4'b0011}};
`endif
        end else if (r_state == SHIFT) begin
            r_shift  <= w_cat[W-1:0];
            r_scr    <= w_scr_nxt;
            r_sticky <= r_sticky | w_lost;
            r_cnt    <= r_cnt - 1'b1;
            if (w_last) begin
                r_state <= DONE;
                r_bcd   <= w_scr_nxt;
                r_ovf   <= r_sticky | w_lost;
`ifdef BIN_TO_BCD_EX3_OUT_EN
                r_ex3   <= w_ex3;
`endif
            end
        end else if (bus.start) begin
            r_state  <= SHIFT;
            r_shift  <= bus.bin;
            r_scr    <= '0;
            r_cnt    <= CW'(W);
            r_sticky <= 1'b0;
        end else begin
            r_state <= IDLE;
        end
    end

    assign bus.busy     = (r_state == SHIFT);
    assign bus.done     = (r_state == DONE);
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_ovf;
`ifdef BIN_TO_BCD_EX3_OUT_EN
    assign bus.ex3      = r_ex3;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench driving a 3-digit and a 2-digit converter with identical stimulus.
module tb_bin_to_bcd_seq;
    localparam int W = 8;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bin;
    int         cyc;
    int         n_chk;
    int         n_fail;
    exp_t       q3[$];
    exp_t       q2[$];
    logic [11:0] last3;
    logic [11:0] last2;
    logic        pd3;
    logic        pd2;

    bin_to_bcd_seq_if #(.W(W), .DIGITS(3)) b3();
    bin_to_bcd_seq_if #(.W(W), .DIGITS(2)) b2();

    bin_to_bcd_seq #(.W(W), .DIGITS(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
    bin_to_bcd_seq #(.W(W), .DIGITS(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

    assign b3.start = start;
    assign b3.bin   = bin;
    assign b2.start = start;
    assign b2.bin   = bin;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v, input int nd);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i+:4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] ex3_of(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[4*i+:4] = b[4*i+:4] + 4'd3;
        return r;
    endfunction

    task automatic push(input int v);
        q3.push_back('{to_bcd(v, 3), v >= 1000, cyc + W + 1});
        q2.push_back('{to_bcd(v, 2), v >= 100, cyc + W + 1});
    endtask

    // junk=1 keeps start high during the shift; bin is scrambled every shift cycle.
    task automatic conv(input int v, input bit junk);
        start = 1'b1;
        bin   = v[7:0];
        push(v);
        for (int i = 0; i <= W; i++) begin
            @(posedge clk);
            #1;
            chk("busy", {31'd0, b3.busy}, {31'd0, i < W});
            if (i < W) begin
                start = junk;
                bin   = 8'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset();
        chk("rst_busy3", {31'd0, b3.busy}, 0);
        chk("rst_done3", {31'd0, b3.done}, 0);
        chk("rst_bcd3", {20'd0, b3.bcd}, 0);
        chk("rst_ovf3", {31'd0, b3.overflow}, 0);
        chk("rst_bcd2", {24'd0, b2.bcd}, 0);
        chk("rst_ovf2", {31'd0, b2.overflow}, 0);
`ifdef BIN_TO_BCD_EX3_OUT_EN
        chk("rst_ex3", {20'd0, b3.ex3}, 32'h333);
`endif
    endtask

    // Reset lands on the n-th edge after the accepting edge; no result is expected.
    task automatic abort(input int v, input int n);
        start = 1'b1;
        bin   = v[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last3 = '0;
            pd3   = 1'b0;
        end else if (b3.done) begin
            chk("q3_has_entry", {31'd0, q3.size() != 0}, 1);
            if (q3.size() != 0) begin
                exp_t e;
                e = q3.pop_front();
                chk("bcd3", {20'd0, b3.bcd}, {20'd0, e.bcd});
                chk("ovf3", {31'd0, b3.overflow}, {31'd0, e.ovf});
                chk("latency3", cyc, e.cyc);
`ifdef BIN_TO_BCD_EX3_OUT_EN
                chk("ex3", {20'd0, b3.ex3}, {20'd0, ex3_of(e.bcd)});
`endif
                last3 = e.bcd;
            end
            chk("done_width3", {31'd0, pd3}, 0);
            chk("busy_in_done3", {31'd0, b3.busy}, 0);
            pd3 = 1'b1;
        end else begin
            chk("hold3", {20'd0, b3.bcd}, {20'd0, last3});
            pd3 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last2 = '0;
            pd2   = 1'b0;
        end else if (b2.done) begin
            chk("q2_has_entry", {31'd0, q2.size() != 0}, 1);
            if (q2.size() != 0) begin
                exp_t e;
                e = q2.pop_front();
                chk("bcd2", {24'd0, b2.bcd}, {20'd0, e.bcd});
                chk("ovf2", {31'd0, b2.overflow}, {31'd0, e.ovf});
                chk("latency2", cyc, e.cyc);
                last2 = e.bcd;
            end
            chk("done_width2", {31'd0, pd2}, 0);
            pd2 = 1'b1;
        end else begin
            chk("hold2", {24'd0, b2.bcd}, {20'd0, last2});
            pd2 = 1'b0;
        end
    end

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bin    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();
        conv(0, 0);
        conv(255, 1);
        conv(137, 1);
        conv(200, 1);
        idle(2);
        conv(99, 0);
        conv(100, 0);
        abort(123, 4);
        idle(W + 3);
        conv(45, 0);
        for (int v = 0; v < 256; v++) conv(v, 1'($urandom));
        for (int k = 0; k < 20; k++) begin
            conv(int'($urandom_range(0, 255)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(W + 4);
        chk("q3_drained", q3.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
